// File: rtl/wb_commit.sv
// Writeback commit: regfile write port, HI/LO and LLbit bypass, link FSM.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_commit #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          wb_wd,
    input  logic                wb_wreg,
    input  logic [31:0]         wb_wdata,
    input  logic [31:0]         wb_hi,
    input  logic [31:0]         wb_lo,
    input  logic                wb_whilo,
    input  logic                wb_LLbit_we,
    input  logic                wb_LLbit_value,
    input  logic                flush,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [31:0]         hi_o,
    output logic [31:0]         lo_o,
    output logic                LLbit_o,
    output logic                link_state_o,
    output logic [RETIRE_W-1:0] retire_cnt_o
);

    typedef enum logic {
        LINK_IDLE = 1'b0,
        LINK_SET  = 1'b1
    } link_t;

    link_t       state;
    link_t       state_nxt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // r0 is hardwired to zero, so writes to it are dropped here
    assign rf_we    = wb_wreg & (wb_wd != 5'd0);
    assign rf_waddr = wb_wd;
    assign rf_wdata = wb_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (wb_whilo) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    assign hi_o = wb_whilo ? wb_hi : hi_q;
    assign lo_o = wb_whilo ? wb_lo : lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LINK_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        LLbit_o   = (state == LINK_SET);
        unique case (state)
            LINK_IDLE: begin
                if (wb_LLbit_we & wb_LLbit_value & ~flush)
                    state_nxt = LINK_SET;
            end
            LINK_SET: begin
                if (flush | (wb_LLbit_we & ~wb_LLbit_value))
                    state_nxt = LINK_IDLE;
            end
            default: state_nxt = LINK_IDLE;
        endcase
        // flush kills an in-flight SC even if an LL writes this cycle
        if (flush)            LLbit_o = 1'b0;
        else if (wb_LLbit_we) LLbit_o = wb_LLbit_value;
    end

    assign link_state_o = (state == LINK_SET);

`ifdef WB_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (rf_we | wb_whilo)
            cnt_q <= cnt_q + RETIRE_W'(1);
    end

    assign retire_cnt_o = cnt_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule
